// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter driven by a shared baud tick.
//   A one-entry holding register takes words over valid/ready; the shift register
//   serialises start(0), DATA_WIDTH bits LSB first, optional parity and 1-2 stop(1)
//   bits. A word waiting in the holding register starts right after the last stop
//   bit, so back-to-back frames have no idle gap.
// Ports:
//   clk      system clock, all logic on posedge
//   rst_n    asynchronous active-low reset
//   tick     one-clk strobe per bit period
//   data_in  word to send, captured when valid && ready
//   valid    data_in valid
//   ready    holding register empty (combinational)
//   tx       serial line, registered, idle high
//   busy     high in any state other than idle
//   done     one-clk pulse on the tick that ends the last stop bit
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  hold_full_q, hold_full_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  parity_q, parity_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  accept, load, last_data, last_stop;

  assign ready     = ~hold_full_q;
  assign accept    = valid & ~hold_full_q;
  assign last_data = (bit_cnt_q == CntW'(DATA_WIDTH - 1));
  assign last_stop = (STOP_BITS == 1) || stop_cnt_q;
  // Transfer hold -> shift from idle, or straight out of the final stop bit.
  assign load      = tick && hold_full_q &&
                     ((state_q == StIdle) || ((state_q == StStop) && last_stop));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StIdle:   if (hold_full_q) state_d = StStart;
        StStart:  state_d = StData;
        StData:   if (last_data) state_d = (PARITY_EN != 0) ? StParity : StStop;
        StParity: state_d = StStop;
        StStop:   if (last_stop) state_d = hold_full_q ? StStart : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    parity_d    = parity_q;
    stop_cnt_d  = stop_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    // accept and load are exclusive: accept needs an empty holder, load a full one.
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        StStart: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
        StData: begin
          if (last_data) begin
            tx_d       = (PARITY_EN != 0) ? parity_q : 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StParity: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        StStop: begin
          if (last_stop) begin
            done_d     = 1'b1;
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Load last so the start bit overrides the stop-bit default above.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      parity_d    = (^hold_q) ^ (PARITY_ODD != 0);
      tx_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      parity_q    <= 1'b0;
      stop_cnt_q  <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
      parity_q    <= parity_d;
      stop_cnt_q  <= stop_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule
